// File: rtl/chan_scan_pkg.sv
// Shared types and constants for the per-channel scan sequencer.
package chan_scan_pkg;

    localparam int NCH             = 16;
    localparam int CH_W            = 4;
    localparam int SETTLE_CYC_DEF  = 1000;
    localparam int TIMEOUT_CYC_DEF = 4096;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FIND,
        S_POT,
        S_SETTLE,
        S_CONV,
        S_WAIT,
        S_READ,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/find_next_set.sv
// Combinational search for the lowest set mask bit at or above a start index.
module find_next_set
    import chan_scan_pkg::*;
(
    input  logic [NCH-1:0]  mask,
    input  logic [CH_W-1:0] start,
    output logic            found,
    output logic [CH_W-1:0] idx
);

    logic [NCH-1:0] qual;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_qual
        assign qual[gi] = mask[gi] && (CH_W'(gi) >= start);
    end

    // Walk downwards so the lowest qualifying bit is the one left in idx.
    always_comb begin
        found = |qual;
        idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (qual[i]) begin
                idx = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/chan_scan_seq.sv
// Scan sequencer: per enabled channel, load the pot over SPI, settle, convert,
// read the ADC and stream one result word out; handshakes are timeout-guarded.
module chan_scan_seq
    import chan_scan_pkg::*;
#(
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NCH-1:0]  phase_en,
    input  logic [NCH-1:0]  sample_en,
    input  logic [NCH-1:0]  read_en,
    input  logic [15:0]     pot_word,
    output logic            pot_req,
    output logic [CH_W-1:0] pot_ch,
    output logic [15:0]     pot_data,
    input  logic            pot_ack,
    output logic [CH_W-1:0] adc_ch,
    output logic            adc_conv,
    input  logic            adc_busy,
    output logic            adc_rd_req,
    input  logic            adc_rd_ack,
    input  logic [15:0]     adc_data,
    output logic            res_valid,
    output logic [CH_W-1:0] res_ch,
    output logic [15:0]     res_data,
    output logic            busy,
    output logic            done,
    output logic [NCH-1:0]  err
);

    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t          state;
    logic [CH_W-1:0] cur;
    logic [CNT_W-1:0] cnt;
    logic [NCH-1:0]  phase_m;
    logic [NCH-1:0]  sample_m;
    logic [NCH-1:0]  read_m;
    logic [15:0]     word_q;

    logic            nxt_found;
    logic [CH_W-1:0] nxt_idx;
    logic            last_ch;
    logic            settle_end;
    logic            tmo_end;
    logic            first_cyc;

    find_next_set u_find (
        .mask  (phase_m),
        .start (cur),
        .found (nxt_found),
        .idx   (nxt_idx)
    );

    assign last_ch    = (cur == CH_W'(NCH - 1));
    assign settle_end = (cnt == CNT_W'(SETTLE_CYC - 1));
    assign tmo_end    = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign first_cyc  = (cnt == '0);

    // cnt is the number of cycles already spent in the current state; every
    // transition clears it so both settle and timeout count from state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cur        <= '0;
            cnt        <= '0;
            phase_m    <= '0;
            sample_m   <= '0;
            read_m     <= '0;
            word_q     <= '0;
            pot_req    <= 1'b0;
            pot_ch     <= '0;
            pot_data   <= '0;
            adc_ch     <= '0;
            adc_conv   <= 1'b0;
            adc_rd_req <= 1'b0;
            res_valid  <= 1'b0;
            res_ch     <= '0;
            res_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= '0;
        end else begin
            adc_conv  <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            cnt       <= cnt + CNT_W'(1);

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        phase_m  <= phase_en;
                        sample_m <= sample_en;
                        read_m   <= read_en;
                        word_q   <= pot_word;
                        cur      <= '0;
                        err      <= '0;
                        busy     <= 1'b1;
                        state    <= S_FIND;
                    end
                end

                S_FIND: begin
                    cnt <= '0;
                    if (nxt_found) begin
                        cur      <= nxt_idx;
                        pot_req  <= 1'b1;
                        pot_ch   <= nxt_idx;
                        pot_data <= word_q;
                        state    <= S_POT;
                    end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_POT: begin
                    if (pot_ack) begin
                        pot_req <= 1'b0;
                        cnt     <= '0;
                        state   <= S_SETTLE;
                    end else if (tmo_end) begin
                        pot_req  <= 1'b0;
                        err[cur] <= 1'b1;
                        cnt      <= '0;
                        state    <= last_ch ? S_DONE : S_FIND;
                        done     <= last_ch;
                        if (!last_ch) cur <= cur + CH_W'(1);
                    end
                end

                S_SETTLE: begin
                    if (settle_end) begin
                        cnt <= '0;
                        if (sample_m[cur]) begin
                            adc_conv <= 1'b1;
                            adc_ch   <= cur;
                            state    <= S_CONV;
                        end else if (read_m[cur]) begin
                            adc_rd_req <= 1'b1;
                            adc_ch     <= cur;
                            state      <= S_READ;
                        end else begin
                            state <= last_ch ? S_DONE : S_FIND;
                            done  <= last_ch;
                            if (!last_ch) cur <= cur + CH_W'(1);
                        end
                    end
                end

                S_CONV: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end

                // The ADC may not raise busy until after the trigger, so the
                // first cycle here never counts as conversion complete.
                S_WAIT: begin
                    if (!first_cyc && !adc_busy) begin
                        cnt <= '0;
                        if (read_m[cur]) begin
                            adc_rd_req <= 1'b1;
                            state      <= S_READ;
                        end else begin
                            state <= last_ch ? S_DONE : S_FIND;
                            done  <= last_ch;
                            if (!last_ch) cur <= cur + CH_W'(1);
                        end
                    end else if (tmo_end) begin
                        err[cur] <= 1'b1;
                        cnt      <= '0;
                        state    <= last_ch ? S_DONE : S_FIND;
                        done     <= last_ch;
                        if (!last_ch) cur <= cur + CH_W'(1);
                    end
                end

                S_READ: begin
                    if (adc_rd_ack) begin
                        adc_rd_req <= 1'b0;
                        res_data   <= adc_data;
                        res_ch     <= cur;
                        res_valid  <= 1'b1;
                        cnt        <= '0;
                        state      <= S_EMIT;
                    end else if (tmo_end) begin
                        adc_rd_req <= 1'b0;
                        err[cur]   <= 1'b1;
                        cnt        <= '0;
                        state      <= last_ch ? S_DONE : S_FIND;
                        done       <= last_ch;
                        if (!last_ch) cur <= cur + CH_W'(1);
                    end
                end

                S_EMIT: begin
                    cnt   <= '0;
                    state <= last_ch ? S_DONE : S_FIND;
                    done  <= last_ch;
                    if (!last_ch) cur <= cur + CH_W'(1);
                end

                S_DONE: begin
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chan_scan_seq.sv
// Directed bench for chan_scan_seq with behavioural SPI/ADC responders and a
// queue scoreboard of expected pot writes, conversions and result words.
module tb_chan_scan_seq;
    import chan_scan_pkg::*;

    localparam int S = 5;
    localparam int T = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NCH-1:0]  phase_en = '0;
    logic [NCH-1:0]  sample_en = '0;
    logic [NCH-1:0]  read_en = '0;
    logic [15:0]     pot_word = '0;
    logic            pot_req;
    logic [CH_W-1:0] pot_ch;
    logic [15:0]     pot_data;
    logic            pot_ack = 1'b0;
    logic [CH_W-1:0] adc_ch;
    logic            adc_conv;
    logic            adc_busy = 1'b0;
    logic            adc_rd_req;
    logic            adc_rd_ack = 1'b0;
    logic [15:0]     adc_data = '0;
    logic            res_valid;
    logic [CH_W-1:0] res_ch;
    logic [15:0]     res_data;
    logic            busy;
    logic            done;
    logic [NCH-1:0]  err;

    chan_scan_seq #(.SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .phase_en   (phase_en),
        .sample_en  (sample_en),
        .read_en    (read_en),
        .pot_word   (pot_word),
        .pot_req    (pot_req),
        .pot_ch     (pot_ch),
        .pot_data   (pot_data),
        .pot_ack    (pot_ack),
        .adc_ch     (adc_ch),
        .adc_conv   (adc_conv),
        .adc_busy   (adc_busy),
        .adc_rd_req (adc_rd_req),
        .adc_rd_ack (adc_rd_ack),
        .adc_data   (adc_data),
        .res_valid  (res_valid),
        .res_ch     (res_ch),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Responder knobs: pot_lat 0 means the SPI never acknowledges.
    int          pot_lat = 1;
    int          pot_cnt = 0;
    int          busy_lat = 3;
    int          busy_left = 0;
    bit          busy_stuck = 1'b0;
    logic [15:0] conv_value = 16'hA5A5;
    logic [15:0] adc_last = 16'h0000;

    always @(posedge clk) begin
        #1;
        if (pot_req && pot_lat != 0 && !pot_ack) begin
            pot_cnt++;
            pot_ack = (pot_cnt == pot_lat);
        end else begin
            pot_ack = 1'b0;
            if (!pot_req) pot_cnt = 0;
        end
        if (adc_conv) begin
            busy_left = busy_lat;
            adc_last  = conv_value;
        end
        adc_busy = busy_stuck || (busy_left > 0);
        if (busy_left > 0) busy_left--;
        if (adc_rd_req && !adc_rd_ack) begin
            adc_rd_ack = 1'b1;
            adc_data   = adc_last;
        end else begin
            adc_rd_ack = 1'b0;
            adc_data   = 16'h0000;
        end
    end

    // Scoreboard state
    int          exp_pot[$];
    int          exp_conv[$];
    logic [31:0] exp_res[$];
    logic [15:0] exp_word = '0;
    logic [15:0] exp_err = '0;
    logic [15:0] model_last = 16'h0000;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    int          done_cyc = 0;
    int          conv_cyc = 0;
    int          pot_rise_cyc = 0;
    int          pot_fall_cyc = 0;
    logic        pot_req_d = 1'b0;
    logic [31:0] mon_e;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pot_req && !pot_req_d) begin
            pot_rise_cyc = cyc;
            if (exp_pot.size() != 0) mon_e = 32'(exp_pot.pop_front());
            else mon_e = 32'hFFFF_FFFF;
            check("pot_ch", 32'(pot_ch), mon_e);
            check("pot_data", 32'(pot_data), 32'(exp_word));
        end
        if (!pot_req && pot_req_d) pot_fall_cyc = cyc;
        pot_req_d = pot_req;
        if (adc_conv) begin
            conv_cyc = cyc;
            if (exp_conv.size() != 0) mon_e = 32'(exp_conv.pop_front());
            else mon_e = 32'hFFFF_FFFF;
            check("conv_ch", 32'(adc_ch), mon_e);
        end
        if (res_valid) begin
            if (exp_res.size() != 0) mon_e = exp_res.pop_front();
            else mon_e = 32'hFFFF_FFFF;
            check("result", {12'h0, res_ch, res_data}, mon_e);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check_idle_outs(input string tag);
        check({tag, "_ctl"}, 32'({pot_req, adc_conv, adc_rd_req, res_valid, busy, done}), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
        check({tag, "_res_data"}, 32'(res_data), 32'h0);
        check({tag, "_pot_data"}, 32'(pot_data), 32'h0);
        check({tag, "_chans"}, 32'({pot_ch, adc_ch, res_ch}), 32'h0);
    endtask

    // Push expectations for a pass, then pulse start for one cycle.
    task automatic launch(input logic [15:0] ph, input logic [15:0] sa,
                          input logic [15:0] rd, input logic [15:0] wd);
        logic [15:0] e;
        e = '0;
        phase_en  = ph;
        sample_en = sa;
        read_en   = rd;
        pot_word  = wd;
        exp_word  = wd;
        for (int c = 0; c < NCH; c++) begin
            if (ph[c]) begin
                exp_pot.push_back(c);
                if (pot_lat == 0) begin
                    e[c] = 1'b1;
                end else if (sa[c]) begin
                    exp_conv.push_back(c);
                    model_last = conv_value;
                    if (busy_stuck) e[c] = 1'b1;
                    else if (rd[c]) exp_res.push_back({12'h0, 4'(c), model_last});
                end else if (rd[c]) begin
                    exp_res.push_back({12'h0, 4'(c), model_last});
                end
            end
        end
        exp_err   = e;
        done_base = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_pass(input string tag);
        int n;
        n = 0;
        while (done_cnt == done_base && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, 32'(done_cnt - done_base), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_left"}, 32'(exp_pot.size() + exp_conv.size() + exp_res.size()), 32'h0);
        $display("pass %s: err=0x%04h done_cnt=%0d", tag, err, done_cnt);
    endtask

    initial begin
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Two channels visited, both converted, only ch2 read back.
        conv_value = 16'hA5A5;
        launch(16'h0005, 16'h0005, 16'h0004, 16'h11AB);
        finish_pass("basic");
        check("basic_settle_lat", 32'(conv_cyc - pot_rise_cyc), 32'(1 + S));

        // Empty phase mask: FIND, DONE, IDLE on consecutive cycles.
        launch(16'h0000, 16'hFFFF, 16'hFFFF, 16'h2222);
        @(negedge clk);
        check("empty_busy_find", 32'({busy, done}), 32'b10);
        @(negedge clk);
        check("empty_done", 32'({busy, done}), 32'b11);
        @(negedge clk);
        check("empty_idle", 32'({busy, done}), 32'b00);
        finish_pass("empty");

        // ADC busy stuck: WAIT times out on the last channel.
        busy_stuck = 1'b1;
        launch(16'h8000, 16'h8000, 16'h8000, 16'h3333);
        finish_pass("stuck");
        check("stuck_wait_len", 32'(done_cyc - conv_cyc), 32'(T + 1));
        busy_stuck = 1'b0;

        // Pot ack lands on the final cycle before timeout: ack wins.
        pot_lat = T;
        conv_value = 16'h5A5A;
        launch(16'h0002, 16'h0002, 16'h0000, 16'h4444);
        finish_pass("late_ack");
        check("late_ack_pot_len", 32'(pot_fall_cyc - pot_rise_cyc), 32'(T));
        check("late_ack_conv_lat", 32'(conv_cyc - pot_rise_cyc), 32'(T + S));

        // Pot never acks: both channels flagged and skipped.
        pot_lat = 0;
        launch(16'h0003, 16'h0003, 16'h0001, 16'h5555);
        finish_pass("pot_tmo");
        check("pot_tmo_len", 32'(pot_fall_cyc - pot_rise_cyc), 32'(T));
        pot_lat = 1;

        // Restart request and mask changes mid-pass must be ignored.
        conv_value = 16'h3C3C;
        launch(16'h0041, 16'h0041, 16'h0041, 16'h6666);
        repeat (3) @(posedge clk);
        #1;
        start     = 1'b1;
        phase_en  = 16'hFFFF;
        sample_en = 16'hFFFF;
        read_en   = 16'hFFFF;
        pot_word  = 16'hFFFF;
        @(posedge clk); #1 start = 1'b0;
        finish_pass("ignore");

        // Read without sampling returns the previous conversion.
        conv_value = 16'h1234;
        launch(16'h0030, 16'h0010, 16'h0030, 16'h7777);
        finish_pass("stale_read");

        // Reset while ch3 is settling aborts the pass on the spot.
        conv_value = 16'h0F0F;
        launch(16'h0008, 16'h0008, 16'h0008, 16'h8888);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pot_req && pot_ch == 4'd3) && n < 500);
        do begin
            @(negedge clk);
            n++;
        end while (pot_req && n < 500);
        check("abort_reached_settle", 32'({pot_req, busy}), 32'b01);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check_idle_outs("abort");
        exp_pot.delete();
        exp_conv.delete();
        exp_res.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - done_base), 32'h0);

        launch(16'h0009, 16'h0009, 16'h0001, 16'h9999);
        finish_pass("after_abort");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/chan_scan_seq.md
# chan_scan_seq

Per-channel scan sequencer driving the front end configured by the FSMC decode registers. On a start pulse it latches the phase/sample/read enable masks and the MCP41010 command word, then walks channels 0→NCH-1. For each enabled channel: load the digital pot over the SPI master, wait a settle time, trigger an ADC conversion and read the result. Results stream out one word per channel to the FSMC readback FIFO.

## Interface
- NCH, 16: channel count. Mask widths equal NCH; channel index is 4 bits.
- SETTLE_CYC, 1000: clk cycles between pot write ack and conversion trigger (≥1).
- TIMEOUT_CYC, 4096: maximum wait on any handshake before abandoning the step (≥2).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle scan request; ignored while busy.
- phase_en  in  NCH  channels to visit.
- sample_en  in  NCH  channels to convert.
- read_en  in  NCH  channels to read back.
- pot_word  in  16  MCP41010 command+data word, same for every channel in a pass.
- pot_req  out  1  level; held until pot_ack or timeout.
- pot_ch  out  4  target channel for pot write; valid while pot_req.
- pot_data  out  16  latched pot_word; valid while pot_req.
- pot_ack  in  1  SPI transfer complete.
- adc_ch  out  4  channel under conversion/read.
- adc_conv  out  1  one-cycle conversion trigger.
- adc_busy  in  1  ADC converting.
- adc_rd_req  out  1  level; held until adc_rd_ack or timeout.
- adc_rd_ack  in  1  adc_data valid this cycle.
- adc_data  in  16  conversion result.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  4  channel of result.
- res_data  out  16  result word.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle end-of-pass pulse.
- err  out  NCH  sticky per-channel timeout flags; cleared on accepted start.

## Operation
- States: IDLE, FIND, POT, SETTLE, CONV, WAIT, READ, EMIT, DONE.
- IDLE: start=1 latches masks, pot_word, cur=0, clears err → FIND.
- FIND: next set bit of phase mask at index ≥ cur. Found → cur=that index, POT. None → DONE.
- POT: pot_req=1. On pot_ack → SETTLE. Timeout → err[cur]=1, go to NEXT handling (skip channel).
- SETTLE: count SETTLE_CYC cycles → CONV if sample_en[cur], else READ if read_en[cur], else advance.
- CONV: adc_conv=1 for one cycle → WAIT.
- WAIT: adc_busy ignored in the first WAIT cycle. From the second cycle on, adc_busy=0 exits: to READ if read_en[cur], else advance. Timeout → err[cur]=1, advance. Read is skipped on timeout.
- READ: adc_rd_req=1. On adc_rd_ack capture adc_data → EMIT. Timeout → err[cur]=1, advance.
- EMIT: res_valid=1, res_ch=cur, res_data=captured → advance.
- Advance: cur=15 → DONE; else cur+1 → FIND.
- A read with sample_en=0 returns the ADC's previous conversion; this is legal.
- DONE: done=1 for one cycle → IDLE.
- Timeout counter resets on every state entry. It expires when the state has been occupied TIMEOUT_CYC cycles without its exit event.

## Timing
- Reset: state IDLE; all outputs 0, including err, res_data, pot_data, adc_ch and pot_ch.
- start at edge k → busy=1 and FIND at k+1.
- Empty phase mask: FIND at k+1, DONE at k+2 (done=1), IDLE at k+3.
- pot_ack at edge j → SETTLE at j+1. First adc_conv occurs SETTLE_CYC cycles after SETTLE entry.
- adc_rd_ack at edge j → res_valid at j+1.
- Ack arriving in the same cycle as timeout expiry: the ack wins, and no err is set.
- Inputs other than the handshakes are only sampled at start; mask changes mid-pass have no effect.
- Reset asserted mid-pass aborts immediately to reset values. No done or res_valid is emitted.

## Structure
- Package chan_scan_pkg holds:
  - the state enum;
  - NCH;
  - the channel index width;
  - default SETTLE_CYC and TIMEOUT_CYC.
- Sub-module find_next_set: combinational lowest-set-bit search at index ≥ start over an NCH-bit mask, with found flag and 4-bit index.

## Test plan
- phase=0x0005, sample=0x0005, read=0x0004, ideal responders → two pot_req (ch0, ch2). Two adc_conv. One res_valid (ch2, data=0xA5A5). done once; err=0.
- phase=0x0000, start → done two cycles after start; no pot_req, adc_conv or res_valid.
- phase=0x8000, adc_busy stuck high → err=0x8000 after TIMEOUT_CYC WAIT cycles; no res_valid; done asserted.
- pot_ack on the exact timeout cycle → no err; SETTLE entered.
- start pulsed while busy, and phase_en changed mid-pass → ignored; channel set stays as latched.
- rst low during SETTLE of ch3 → all outputs 0 the next cycle. A fresh start afterwards runs a clean pass from ch0.
